darray_gather: RTL

Collects a stream of N-bit words arriving one per valid/ready beat and presents them as one M-lane frame on an unpacked-array output port (`[N-1:0] out_data [0:M-1]`). It is the producer side of the unpacked-array port interface: it builds the array that downstream array-input blocks, such as the register stage, consume. It sits between serial or narrow sources and any M-lane array consumer, and handshakes on both sides.

---
 rtl/darray_gather_if.sv | 39 +++
 rtl/darray_gather.sv | 92 +++++++++
 2 files changed

// File: rtl/darray_gather_if.sv
// darray_gather handshake bundle: word stream in, M-lane frame out.
// master drives words and out_ready; slave is the gather block.
interface darray_gather_if #(
  parameter int N = 2,
  parameter int M = 2
);
  localparam int CW = $clog2(M + 1);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data [0:M-1];
  logic [CW-1:0] out_count;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_count
  );
endinterface

// File: rtl/darray_gather.sv
// darray_gather: packs N-bit words into an M-lane frame.
// DARRAY_GATHER_LAST_EN enables early frame close on in_last.
module darray_gather #(
  parameter int N = 2,
  parameter int M = 2
) (
  input logic            clock,
  input logic            reset,
  darray_gather_if.slave bus
);
  localparam int IW = $clog2(M);
  localparam int CW = $clog2(M + 1);
  localparam logic [IW-1:0] LAST = IW'(M - 1);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [N-1:0]  lane   [0:M-1];
  logic [N-1:0]  lane_n [0:M-1];
  logic          accept;
  logic          close;

  assign bus.in_ready  = (state == FILL) && !reset;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_count = cnt;
  assign bus.out_data  = lane;

  assign accept = bus.in_valid && bus.in_ready;

`ifdef DARRAY_GATHER_LAST_EN
  assign close = accept && ((idx == LAST) || bus.in_last);
`else
  logic unused_last;
  assign unused_last = bus.in_last;
  assign close = accept && (idx == LAST);
`endif

  // Next-state: fill lanes, close the frame, release it on out_ready
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    lane_n  = lane;
    unique case (state)
      FILL: begin
        if (accept) begin
          lane_n[idx] = bus.in_data;
          idx_n       = idx + IW'(1);
        end
        if (close) begin
          state_n = HOLD;
          cnt_n   = CW'(idx) + CW'(1);
`ifdef DARRAY_GATHER_LAST_EN
          for (int k = 0; k < M; k++) begin
            if (k > int'(idx)) lane_n[k] = '0;
          end
`endif
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_n = FILL;
          idx_n   = '0;
        end
      end
      default: state_n = FILL;
    endcase
  end

  // State, index, count and lane registers; reset drops any frame
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      idx   <= '0;
      cnt   <= '0;
      for (int k = 0; k < M; k++) lane[k] <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      lane  <= lane_n;
    end
  end
endmodule
